instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction memory interface.
- Owns the fetch PC and drives the word-aligned byte address to the combinational instruction memory.
- Captures each returned 32-bit instruction word together with its PC into a small prefetch queue.
- Presents queued instructions to decode with a valid/ready handshake, and supports branch redirect with queue flush and a fetch-enable hold.

Parameters:
ADDR_SIZE, 64, address/PC width in bits
INSTR_SIZE, 32, instruction word width in bits
DEPTH, 4, prefetch queue entries (power of two, >=2)
LOG_DEPTH, 2, log2(DEPTH)
RESET_PC, 0, PC loaded at reset (bits [1:0] must be 0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_address  output  ADDR_SIZE  byte address to instruction memory; always equals fetch_pc
imem_data  input  INSTR_SIZE  instruction word returned combinationally for imem_address in the same cycle
fetch_en  input  1  1 = fetch allowed; 0 = hold fetch_pc, no push
redirect_valid  input  1  branch/exception redirect request
redirect_pc  input  ADDR_SIZE  redirect target; bits [1:0] ignored (forced 0)
out_valid  output  1  head entry valid to decode
out_ready  input  1  decode accepts head this cycle
out_instr  output  INSTR_SIZE  head instruction word
out_pc  output  ADDR_SIZE  PC of head instruction
queue_count  output  LOG_DEPTH+1  number of valid entries (0..DEPTH)

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; queue empty.
  - Read/write pointers = 0; queue_count = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0.
  - Queue storage is not reset.
- Reset asserted mid-operation discards all entries immediately; on release, fetching restarts from RESET_PC.
- imem_address = fetch_pc, combinational. The memory ignores bits [1:0] and bits above its depth; this unit always keeps bits [1:0] = 0.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (queue_count < DEPTH | pop).
  - Push is allowed when full only if a pop occurs the same cycle.
- On push (clock edge):
  - entry[wr_ptr] <= {fetch_pc, imem_data}.
  - wr_ptr += 1, mod DEPTH.
  - fetch_pc += 4, mod 2^ADDR_SIZE; wraps from all-ones-minus-3 to 0 with no flag.
- On pop: rd_ptr += 1, mod DEPTH.
- queue_count next value:
  - count + 1 on push only.
  - count - 1 on pop only.
  - unchanged when both or neither occur.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1 at the earliest. Head outputs are read from the registered queue; there is no bypass from imem_data.
- out_valid = (queue_count != 0) & ~redirect_valid.
- out_instr and out_pc show entry[rd_ptr] whenever queue_count != 0; they show 0 when empty.
- Redirect takes priority over everything. At the edge where redirect_valid = 1:
  - queue flushed: count = 0, rd_ptr = wr_ptr = 0.
  - fetch_pc <= {redirect_pc[ADDR_SIZE-1:2], 2'b00}.
  - no push and no pop that cycle, regardless of out_ready.
  - fetching resumes from the target the next cycle if fetch_en = 1.
- Back-to-back redirects: the last one wins; the queue stays empty throughout.
- fetch_en = 0: fetch_pc holds and there is no push. Pops continue normally, so the queue drains.
- Stable rule: out_instr and out_pc do not change while out_valid = 1 and out_ready = 0, except on redirect or reset.

Test Plan:
- Memory model word[i] = 0xD5030000 + i; release reset with fetch_en = 1, out_ready = 1.
  -> out_valid first high the cycle after the first edge: out_pc = 0x0, out_instr = 0xD5030000. Then one instruction per cycle with PCs 0x4, 0x8, ...; queue_count stays at 1.
- out_ready = 0 from reset for 6 cycles.
  -> queue_count reaches 4 and stays there; imem_address holds at 0x10; out_pc stays at 0x0. Raise out_ready: PCs 0x0, 0x4, 0x8, 0xC, 0x10 are delivered in order with no gap or duplicate.
- With queue full (count = 4), assert redirect_valid with redirect_pc = 0x107 and out_ready = 1.
  -> out_valid = 0 that cycle; queue_count = 0 next cycle; imem_address = 0x104; next delivered out_pc = 0x104.
- fetch_en = 0 after 2 fetches, with out_ready = 1.
  -> both entries drain, then out_valid = 0; imem_address stays at 0x8 until fetch_en returns to 1.
- RESET_PC = 0xFFFFFFFFFFFFFFF8.
  -> delivered PCs are 0x...FFF8, 0x...FFFC, then 0x0.
- Assert rst_n low asynchronously mid-cycle with 3 entries queued.
  -> out_valid = 0 and queue_count = 0 immediately, without waiting for a clock edge; imem_address = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch PC, combinational imem access, prefetch queue to decode
// clk, rst_n          : clock (rising edge), asynchronous active-low reset
// o_imem_address      : word-aligned byte address to instruction memory (= fetch pc)
// i_imem_data         : instruction word for o_imem_address, same cycle
// i_fetch_en          : 1 allows fetch, 0 holds the fetch pc
// i_redirect_valid/pc : redirect request and target, flushes the queue
// o_out_valid/i_out_ready/o_out_instr/o_out_pc : head entry handshake to decode
// o_queue_count       : number of valid queue entries
module instr_fetch_unit #(
  parameter int ADDR_SIZE = 64,
  parameter int INSTR_SIZE = 32,
  parameter int DEPTH = 4,
  parameter int LOG_DEPTH = 2,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_SIZE-1:0]  o_imem_address,
  input  logic [INSTR_SIZE-1:0] i_imem_data,
  input  logic                  i_fetch_en,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_SIZE-1:0]  i_redirect_pc,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [INSTR_SIZE-1:0] o_out_instr,
  output logic [ADDR_SIZE-1:0]  o_out_pc,
  output logic [LOG_DEPTH:0]    o_queue_count
);
  localparam logic [LOG_DEPTH:0] L_FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] L_ONE = (LOG_DEPTH+1)'(1);
  logic [ADDR_SIZE-1:0]  r_fetch_pc;
  logic [LOG_DEPTH-1:0]  r_wr, r_rd;
  logic [LOG_DEPTH:0]    r_count;
  logic [ADDR_SIZE-1:0]  r_pc_q [DEPTH];
  logic [INSTR_SIZE-1:0] r_instr_q [DEPTH];
  logic w_empty, w_pop, w_push;
  always_comb begin
    w_empty = r_count == '0;
    o_out_valid = ~w_empty & ~i_redirect_valid;
    w_pop = o_out_valid & i_out_ready;
    // a full queue still accepts a fetch when the head leaves in the same cycle
    w_push = i_fetch_en & ~i_redirect_valid & ((r_count < L_FULL) | w_pop);
    o_imem_address = r_fetch_pc;
    o_out_instr = w_empty ? '0 : r_instr_q[r_rd];
    o_out_pc = w_empty ? '0 : r_pc_q[r_rd];
    o_queue_count = r_count;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= {i_redirect_pc[ADDR_SIZE-1:2], 2'b00};
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_fetch_pc <= w_push ? r_fetch_pc + ADDR_SIZE'(4) : r_fetch_pc;
      r_wr <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= (w_push & ~w_pop) ? r_count + L_ONE : (w_pop & ~w_push) ? r_count - L_ONE : r_count;
    end
  always_ff @(posedge clk)
    if (w_push) begin
      r_pc_q[r_wr] <= r_fetch_pc;
      r_instr_q[r_wr] <= i_imem_data;
    end
endmodule
